log_sched: RTL and testbench
============================

# log_sched

Round-robin scheduler that shares one ceil-log2 unit among NREQ requesters. Each requester presents an 8-bit operand through a valid/ready handshake. The scheduler grants one requester per cycle, computes ceil(log2(operand)), and returns the result through a one-entry output register tagged with the requester ID. It sits between the requesting datapaths and the log datapath, so they no longer need a private log unit each.

## Interface
- NREQ, 4: number of requesters, 2..8
- IDW, $clog2(NREQ): requester ID width
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset; synchronous, active-high
- req_valid  input  NREQ  per-requester operand valid
- req_data  input  NREQ*8  packed operands; requester i at [8*i+7:8*i]
- req_ready  output  NREQ  one-hot grant/accept; operand taken when req_valid[i] && req_ready[i]
- resp_valid  output  1  result register holds a result
- resp_ready  input  1  consumer accepts result
- resp_id  output  IDW  requester index of the result
- resp_data  output  4  ceil(log2(operand)); range 0..8
- resp_exact  output  1  operand is a nonzero power of two; present only with LOG_SCHED_EXACT_EN

## Operation
- Arithmetic rules:
  - resp_data = ceil(log2(x)) at full 4-bit width, with no truncation.
  - x=0 -> 0; x=1 -> 0; x=2 -> 1; x=5 -> 3; x=128 -> 7; x=129..255 -> 8.
- Output slot has two states:
  - EMPTY: resp_valid=0.
  - FULL: resp_valid=1.
- Slot can load in a cycle when it is EMPTY, or FULL && resp_ready (drain and refill in the same cycle).
- Arbitration:
  - Round-robin pointer `prio`, IDW bits.
  - Candidate order is prio, prio+1, …, wrapping modulo NREQ.
  - First requester with req_valid=1 is granted.
  - req_ready is one-hot on the granted index, and only when the slot can load; otherwise it is all zeros.
- req_ready depends combinationally on req_valid and resp_ready. No requester's req_ready may depend on its own req_valid through a loop other than the grant selection.
- On accept of requester g:
  - resp_id <= g.
  - resp_data <= clog2(req_data[g]).
  - Slot goes to FULL.
  - prio <= (g+1) mod NREQ.
- prio changes only on an accept. With no accept, prio holds.
- FULL && resp_ready && no request: slot goes to EMPTY.
- FULL && !resp_ready: resp_id, resp_data and resp_exact hold stable. No grant is issued.
- Fairness: with all requesters continuously valid and resp_ready=1, grants rotate 0,1,…,NREQ-1,0,…
  - Every requester is served within NREQ accepts of raising valid.
- Reset: rst=1 at a rising edge forces the slot to EMPTY and prio to 0.
  - Outputs after reset: resp_valid=0, resp_id=0, resp_data=0, resp_exact=0, req_ready=0.
  - Reset overrides a simultaneous accept or drain.
  - A result pending at reset is discarded.
  - Requesters must re-present after reset.

## Timing
- Latency is 1 cycle: an operand accepted at edge N is visible on resp_* after edge N.
- Throughput is one result per cycle while resp_ready=1.
- No combinational path from req_data to resp_*.
- resp_valid, resp_id and resp_data are registered outputs.
- During rst, req_ready=0 combinationally.

## Configuration
- LOG_SCHED_EXACT_EN defined:
  - Adds the resp_exact port.
  - resp_exact is registered alongside resp_data and equals (x!=0 && (x&(x-1))==0).
  - Example: x=64 -> 1; x=65 -> 0; x=0 -> 0.
- LOG_SCHED_EXACT_EN undefined:
  - Port and register are absent.
  - All other behaviour is identical.

## Structure
- Package log_sched_pkg holds:
  - OPW=8 (operand width).
  - RESW=4 (result width).
  - Function clog2_8 for the bench model.
- One sub-module, log_unit: combinational, 8-bit in, 4-bit out, computing ceil(log2) with the rules above. Exactly one instance sits after the grant mux.
- The grant mux, round-robin pointer and output slot live in log_sched.

## Test plan
- Single requester 0, x=5, resp_ready=1 -> resp_valid next cycle, resp_id=0, resp_data=3; slot EMPTY the following cycle.
- Boundary operands 0, 1, 2, 128, 129, 255 via requester 2 -> resp_data 0, 0, 1, 7, 8, 8.
- All 4 requesters valid continuously, resp_ready=1 -> resp_id sequence 0,1,2,3,0,1 on back-to-back cycles.
- Backpressure: resp_ready=0 for 3 cycles with result x=17 pending -> resp_data=5 and resp_id held; req_ready=0; on release, drain and the next grant occur in the same cycle.
- Reset mid-stream: rst asserted while FULL with requesters 1 and 3 valid -> next cycle resp_valid=0 and prio=0; first grant after reset goes to 1.
- With LOG_SCHED_EXACT_EN: x=64 -> resp_exact=1, resp_data=6; x=65 -> resp_exact=0, resp_data=7.

Source files
------------

// File: rtl/log_sched_pkg.sv
// ============================================================================
// Module      : log_sched_pkg
// Description : Shared widths, output-slot state encoding and a reference
//               ceil(log2) function for the log_sched block.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package log_sched_pkg;

    localparam int OPW  = 8;
    localparam int RESW = 4;

    typedef enum logic [0:0] {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

    // ceil(log2(x)) via the index of the top set bit of x-1; 0 and 1 map to 0
    function automatic logic [RESW-1:0] clog2_8(input logic [OPW-1:0] x);
        logic [OPW-1:0]  m;
        logic [RESW-1:0] r;
        r = '0;
        m = '0;
        if (x > 8'd1) begin
            m = x - 8'd1;
            for (int i = 0; i < OPW; i++) begin
                if (m[i]) r = RESW'(i + 1);
            end
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/log_sched_log_unit.sv
// ============================================================================
// Module      : log_unit
// Description : Combinational ceil(log2) of an 8-bit operand, 4-bit result.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module log_unit
    import log_sched_pkg::*;
(
    input  logic [OPW-1:0]  i_x,
    output logic [RESW-1:0] o_res
);

    // ceil(log2 x) equals the number of powers 2^k (k = 0..7) strictly below x
    always_comb begin
        o_res = '0;
        for (int k = 0; k < OPW; k++) begin
            if (i_x > (8'd1 << k)) o_res = o_res + 4'd1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/log_sched.sv
// ============================================================================
// Module      : log_sched
// Description : Round-robin scheduler sharing one ceil-log2 unit among NREQ
//               requesters; one-entry tagged result slot. Optional resp_exact
//               output enabled by LOG_SCHED_EXACT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module log_sched
    import log_sched_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [NREQ*OPW-1:0] req_data,
    output logic [NREQ-1:0]     req_ready,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [IDW-1:0]      resp_id,
    output logic [RESW-1:0]     resp_data
`ifdef LOG_SCHED_EXACT_EN
    ,
    output logic                resp_exact
`endif
);

    slot_state_e     r_state;
    logic [IDW-1:0]  r_prio;
    logic [IDW-1:0]  r_id;
    logic [RESW-1:0] r_data;

    logic            w_can_load;
    logic            w_any;
    logic            w_accept;
    logic [IDW-1:0]  w_gnt;
    logic [IDW-1:0]  w_prio_nxt;
    logic [OPW-1:0]  w_opnd;
    logic [RESW-1:0] w_log;

    assign w_can_load = !rst && ((r_state == SLOT_EMPTY) || resp_ready);
    assign w_accept   = w_can_load && w_any;

    // First valid requester scanning from r_prio upward, wrapping at NREQ
    always_comb begin
        int idx;
        idx   = 0;
        w_any = 1'b0;
        w_gnt = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(r_prio) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!w_any && req_valid[idx]) begin
                w_any = 1'b1;
                w_gnt = IDW'(idx);
            end
        end
    end

    always_comb begin
        w_opnd = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_gnt == IDW'(i)) w_opnd = req_data[OPW*i +: OPW];
        end
    end

    always_comb begin
        req_ready = '0;
        if (w_accept) req_ready[w_gnt] = 1'b1;
    end

    assign w_prio_nxt = (w_gnt == IDW'(NREQ - 1)) ? '0 : w_gnt + IDW'(1);

    log_unit u_log_unit (
        .i_x   (w_opnd),
        .o_res (w_log)
    );

`ifdef LOG_SCHED_EXACT_EN
    logic r_exact;
    logic w_exact;
    assign w_exact    = (w_opnd != '0) && ((w_opnd & (w_opnd - 8'd1)) == '0);
    assign resp_exact = r_exact;

    always_ff @(posedge clk) begin
        if (rst)           r_exact <= 1'b0;
        else if (w_accept) r_exact <= w_exact;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= SLOT_EMPTY;
            r_prio  <= '0;
            r_id    <= '0;
            r_data  <= '0;
        end else if (w_accept) begin
            r_state <= SLOT_FULL;
            r_prio  <= w_prio_nxt;
            r_id    <= w_gnt;
            r_data  <= w_log;
        end else if ((r_state == SLOT_FULL) && resp_ready) begin
            r_state <= SLOT_EMPTY;
        end
    end

    assign resp_valid = (r_state == SLOT_FULL);
    assign resp_id    = r_id;
    assign resp_data  = r_data;

endmodule

`default_nettype wire

// File: tb/tb_log_sched.sv
// ============================================================================
// Module      : tb_log_sched
// Description : Directed self-checking bench for log_sched (NREQ=4); covers
//               resp_exact when LOG_SCHED_EXACT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_log_sched;

    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic              clk;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*8-1:0] req_data;
    logic [NREQ-1:0]   req_ready;
    logic              resp_valid;
    logic              resp_ready;
    logic [IDW-1:0]    resp_id;
    logic [3:0]        resp_data;
`ifdef LOG_SCHED_EXACT_EN
    logic              resp_exact;
`endif

    int n_vec;
    int n_err;

    log_sched #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_data  (resp_data)
`ifdef LOG_SCHED_EXACT_EN
        ,
        .resp_exact (resp_exact)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, observed running expected done");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 ns after the rising edge; checks run 1 ns after that
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_op(input int idx, input logic [7:0] x);
        req_data[8*idx +: 8] = x;
    endtask

    logic [7:0] bnd_op  [6];
    logic [3:0] bnd_exp [6];
    logic [1:0] rr_id   [6];
    logic [3:0] rr_dat  [6];

    initial begin
        n_vec = 0;
        n_err = 0;
        bnd_op  = '{8'd0, 8'd1, 8'd2, 8'd128, 8'd129, 8'd255};
        bnd_exp = '{4'd0, 4'd0, 4'd1, 4'd7,   4'd8,   4'd8};
        rr_id   = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        rr_dat  = '{4'd0, 4'd1, 4'd2, 4'd2, 4'd0, 4'd1};

        // Reset with all requesters valid: req_ready must stay low
        rst        = 1'b1;
        req_valid  = 4'b1111;
        req_data   = '0;
        resp_ready = 1'b1;
        tick();
        tick();
        settle();
        chk("rst_ready", 32'(req_ready), 32'h0);
        chk("rst_valid", 32'(resp_valid), 32'h0);
        chk("rst_id",    32'(resp_id),    32'h0);
        chk("rst_data",  32'(resp_data),  32'h0);
`ifdef LOG_SCHED_EXACT_EN
        chk("rst_exact", 32'(resp_exact), 32'h0);
`endif

        // Single requester 0, x=5
        @(posedge clk); #1;
        rst       = 1'b0;
        req_valid = 4'b0001;
        set_op(0, 8'd5);
        settle();
        chk("single_ready", 32'(req_ready), 32'h1);
        tick();
        req_valid = 4'b0000;
        settle();
        chk("single_valid", 32'(resp_valid), 32'h1);
        chk("single_id",    32'(resp_id),    32'h0);
        chk("single_data",  32'(resp_data),  32'h3);
        chk("idle_ready",   32'(req_ready),  32'h0);
        tick();
        settle();
        chk("single_empty", 32'(resp_valid), 32'h0);

        // Boundary operands on requester 2, back to back (prio is 1 here)
        for (int i = 0; i < 6; i++) begin
            req_valid = 4'b0100;
            set_op(2, bnd_op[i]);
            settle();
            chk("bnd_ready", 32'(req_ready), 32'h4);
            tick();
            settle();
            chk("bnd_valid", 32'(resp_valid), 32'h1);
            chk("bnd_id",    32'(resp_id),    32'h2);
            chk("bnd_data",  32'(resp_data),  32'(bnd_exp[i]));
        end
        req_valid = 4'b0000;
        tick();

        // Move prio to 0 by serving requester 3, then rotate with all valid
        req_valid = 4'b1000;
        set_op(3, 8'd4);
        tick();
        settle();
        chk("pre_rr_id", 32'(resp_id), 32'h3);
        set_op(0, 8'd1);
        set_op(1, 8'd2);
        set_op(2, 8'd3);
        set_op(3, 8'd4);
        req_valid = 4'b1111;
        for (int i = 0; i < 6; i++) begin
            tick();
            settle();
            chk("rr_valid", 32'(resp_valid), 32'h1);
            chk("rr_id",    32'(resp_id),    32'(rr_id[i]));
            chk("rr_data",  32'(resp_data),  32'(rr_dat[i]));
        end
        req_valid = 4'b0000;
        tick();

        // Backpressure with x=17 pending (prio is 2, only req 0 valid)
        req_valid = 4'b0001;
        set_op(0, 8'd17);
        set_op(1, 8'd9);
        tick();
        settle();
        chk("bp_load_data", 32'(resp_data), 32'h5);
        chk("bp_load_id",   32'(resp_id),   32'h0);
        resp_ready = 1'b0;
        req_valid  = 4'b0011;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("bp_ready", 32'(req_ready), 32'h0);
            tick();
            settle();
            chk("bp_valid", 32'(resp_valid), 32'h1);
            chk("bp_data",  32'(resp_data),  32'h5);
            chk("bp_id",    32'(resp_id),    32'h0);
        end
        resp_ready = 1'b1;
        settle();
        chk("bp_release_ready", 32'(req_ready), 32'h2);
        tick();
        settle();
        chk("bp_next_valid", 32'(resp_valid), 32'h1);
        chk("bp_next_id",    32'(resp_id),    32'h1);
        chk("bp_next_data",  32'(resp_data),  32'h4);

        // Reset while FULL with requesters 1 and 3 valid (prio is 2 here)
        req_valid = 4'b1010;
        set_op(1, 8'd3);
        set_op(3, 8'd200);
        rst = 1'b1;
        settle();
        chk("mrst_ready", 32'(req_ready), 32'h0);
        tick();
        settle();
        chk("mrst_valid", 32'(resp_valid), 32'h0);
        chk("mrst_id",    32'(resp_id),    32'h0);
        chk("mrst_data",  32'(resp_data),  32'h0);
        rst = 1'b0;
        settle();
        chk("mrst_first_ready", 32'(req_ready), 32'h2);
        tick();
        settle();
        chk("mrst_first_id",   32'(resp_id),   32'h1);
        chk("mrst_first_data", 32'(resp_data), 32'h2);
        req_valid = 4'b0000;
        tick();

`ifdef LOG_SCHED_EXACT_EN
        // prio is 2; requester 2 sees the operand first
        req_valid = 4'b0100;
        set_op(2, 8'd64);
        tick();
        settle();
        chk("ex64_exact", 32'(resp_exact), 32'h1);
        chk("ex64_data",  32'(resp_data),  32'h6);
        set_op(2, 8'd65);
        tick();
        settle();
        chk("ex65_exact", 32'(resp_exact), 32'h0);
        chk("ex65_data",  32'(resp_data),  32'h7);
        req_valid = 4'b0000;
        tick();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
